sudoku_reduce: RTL and testbench
================================

Name: sudoku_reduce

Overview:
- Iterative candidate-elimination engine that sits directly downstream of sudoku_mask. It holds the per-cell candidate register for a 9x9 puzzle.
- It drives the decided cells to sudoku_mask as a 729-bit one-hot vector. It consumes the returned exclusion mask and clears excluded candidates from undecided cells, one iteration per clock.
- It runs until the puzzle is solved, a contradiction appears, progress stops, or an iteration limit is reached.

Parameters:
- MAX_ITER, 81: maximum number of applied update iterations before timeout.
- CNT_W, 7: width of iter_count; must hold MAX_ITER.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request; loads load_puzzle and begins reduction.
- load_puzzle  input  729  initial candidates; bit cell*9+d = digit d+1 allowed in cell (cell=row*9+col).
- puzzle_reg_bin  output  729  to sudoku_mask; per cell, the candidate vector if exactly one bit is set, else 9'b0.
- puzzle_mask_bin  input  729  from sudoku_mask, combinational from puzzle_reg_bin; 1 = candidate excluded.
- cand_out  output  729  current candidate register.
- busy  output  1  high in LOAD and ITER.
- done  output  1  high in DONE (level).
- solved  output  1  valid while done; every cell has exactly one candidate.
- error  output  1  valid while done; some cell has zero candidates.
- stuck  output  1  valid while done; no progress and not solved.
- timeout  output  1  valid while done; MAX_ITER reached without another outcome.
- iter_count  output  CNT_W  number of updates applied since start.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; cand=0; iter_count=0; busy, done, solved, error, stuck and timeout all 0. puzzle_reg_bin=0 and cand_out=0 follow from cand=0.
- FSM states: IDLE, LOAD, ITER, DONE.
- IDLE or DONE with start=1: go to LOAD. Clear all flags and iter_count. Latch load_puzzle into cand; a cell with all-zero input loads 9'h1FF (empty cell). Multi-hot input is kept as given.
- LOAD -> ITER unconditionally after one cycle. This lets the combinational mask path settle.
- start while busy: ignored.
- ITER evaluation each cycle on the current cand, in priority order:
  1. Any cell has zero candidates -> DONE with error=1.
  2. All 81 cells single-bit -> DONE with solved=1.
  3. cand_next==cand -> DONE with stuck=1.
  4. iter_count==MAX_ITER -> DONE with timeout=1.
  5. Otherwise: cand<=cand_next, iter_count+=1, stay in ITER.
- Exactly one of the four flags is set in DONE.
- cand_next per cell: a decided cell (one-hot) keeps its value. An undecided cell gets cand & ~mask slice[cell*9+8:cell*9].
- Cells become decided only via register update, so newly single cells feed the mask on the next cycle. Throughput is one iteration per clock.
- Popcount rule: "single" means exactly one of the cell's 9 bits is set. This is computed combinationally from cand.
- iter_count saturates at MAX_ITER; it never wraps.
- DONE holds all outputs and cand stable until start or reset.

Test Plan:
- Reset asserted mid-ITER (iter_count=3) -> same cycle: busy=0, done=0, cand_out=0, iter_count=0; state IDLE. A following start runs normally.
- Load a fully valid solved grid -> LOAD, then the first ITER cycle yields done=1, solved=1, iter_count=0. Total latency: start to done = 2 clocks after the start edge.
- Solved grid with cell (4,4) cleared to 0 -> after one update, cell (4,4) holds its correct digit, then solved=1 with iter_count=1.
- All-zero load_puzzle (81 empty cells) -> mask is all 0, no progress, stuck=1, iter_count=0, cand_out all ones.
- Row 0 holds digits 1..8 in cols 0..7, cell (0,8) empty, cell (1,8)=9, all other cells empty -> update 1 clears (0,8) to 9'h000, then error=1, iter_count=1.
- start pulsed while busy=1 -> ignored: the run completes with the original result. A start pulsed in DONE restarts, clearing the flags in the LOAD cycle.

Source files
------------

// File: rtl/sudoku_reduce.sv
// Iterative sudoku candidate eliminator: publishes decided cells to an external
// exclusion-mask block and prunes undecided cells with the returned mask, one pass per clock.
module sudoku_reduce #(
  parameter int MAX_ITER = 81,
  parameter int CNT_W    = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [728:0]     load_puzzle,
  output logic [728:0]     puzzle_reg_bin,
  input  logic [728:0]     puzzle_mask_bin,
  output logic [728:0]     cand_out,
  output logic             busy,
  output logic             done,
  output logic             solved,
  output logic             error,
  output logic             stuck,
  output logic             timeout,
  output logic [CNT_W-1:0] iter_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [728:0] cand;
  logic [728:0] cand_next;
  logic [728:0] load_fixed;
  logic [80:0]  single;
  logic [80:0]  empty;
  logic         all_single;
  logic         any_empty;
  logic         no_change;
  logic         at_limit;
  logic         do_load;
  logic         do_update;
  logic         set_solved;
  logic         set_error;
  logic         set_stuck;
  logic         set_timeout;

  // Per-cell datapath: decided cells are frozen and published, the rest are pruned.
  for (genvar i = 0; i < 81; i++) begin : g_cell
    assign single[i] = ($countones(cand[i*9 +: 9]) == 1);
    assign empty[i]  = (cand[i*9 +: 9] == 9'd0);
    assign puzzle_reg_bin[i*9 +: 9] = single[i] ? cand[i*9 +: 9] : 9'd0;
    assign cand_next[i*9 +: 9] = single[i] ? cand[i*9 +: 9]
                                           : (cand[i*9 +: 9] & ~puzzle_mask_bin[i*9 +: 9]);
    assign load_fixed[i*9 +: 9] = (load_puzzle[i*9 +: 9] == 9'd0) ? 9'h1FF
                                                                  : load_puzzle[i*9 +: 9];
  end

  assign all_single = &single;
  assign any_empty  = |empty;
  assign no_change  = (cand_next == cand);
  assign at_limit   = (iter_count == CNT_W'(MAX_ITER));
  assign cand_out   = cand;
  assign busy       = (state == S_LOAD) || (state == S_ITER);
  assign done       = (state == S_DONE);

  always_comb begin
    state_next  = state;
    do_load     = 1'b0;
    do_update   = 1'b0;
    set_solved  = 1'b0;
    set_error   = 1'b0;
    set_stuck   = 1'b0;
    set_timeout = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_LOAD;
          do_load    = 1'b1;
        end
      end
      S_LOAD: state_next = S_ITER;
      S_ITER: begin
        // Outcome priority: contradiction, solved, no progress, iteration limit.
        if (any_empty) begin
          state_next = S_DONE;
          set_error  = 1'b1;
        end else if (all_single) begin
          state_next = S_DONE;
          set_solved = 1'b1;
        end else if (no_change) begin
          state_next = S_DONE;
          set_stuck  = 1'b1;
        end else if (at_limit) begin
          state_next  = S_DONE;
          set_timeout = 1'b1;
        end else begin
          do_update = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cand       <= '0;
      iter_count <= '0;
      solved     <= 1'b0;
      error      <= 1'b0;
      stuck      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state <= state_next;
      if (do_load) begin
        cand       <= load_fixed;
        iter_count <= '0;
        solved     <= 1'b0;
        error      <= 1'b0;
        stuck      <= 1'b0;
        timeout    <= 1'b0;
      end else begin
        // do_update is never asserted at the limit, so the counter cannot wrap.
        if (do_update) begin
          cand       <= cand_next;
          iter_count <= iter_count + 1'b1;
        end
        if (set_solved)  solved  <= 1'b1;
        if (set_error)   error   <= 1'b1;
        if (set_stuck)   stuck   <= 1'b1;
        if (set_timeout) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sudoku_reduce.sv
// Bench for sudoku_reduce: supplies the peer-exclusion mask, runs directed and
// random puzzles, and compares every cycle against an array-based solver model.
module tb_sudoku_reduce;

  localparam int MAX_ITER = 81;
  localparam int CNT_W    = 7;
  typedef logic [728:0] grid_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  grid_t            load_puzzle = '0;
  grid_t            puzzle_reg_bin;
  grid_t            puzzle_mask_bin;
  grid_t            cand_out;
  logic             busy, done, solved, error, stuck, timeout;
  logic [CNT_W-1:0] iter_count;

  int total = 0;
  int bad   = 0;

  sudoku_reduce #(.MAX_ITER(MAX_ITER), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (rst),
    .start           (start),
    .load_puzzle     (load_puzzle),
    .puzzle_reg_bin  (puzzle_reg_bin),
    .puzzle_mask_bin (puzzle_mask_bin),
    .cand_out        (cand_out),
    .busy            (busy),
    .done            (done),
    .solved          (solved),
    .error           (error),
    .stuck           (stuck),
    .timeout         (timeout),
    .iter_count      (iter_count)
  );

  always #5 clk = ~clk;

  // ---------------- sudoku rules ----------------
  function automatic bit is_peer(int a, int b);
    int ra, ca, rb, cb;
    ra = a / 9; ca = a % 9; rb = b / 9; cb = b % 9;
    return (a != b) && ((ra == rb) || (ca == cb) || ((ra / 3 == rb / 3) && (ca / 3 == cb / 3)));
  endfunction

  function automatic bit one(logic [8:0] v);
    return $countones(v) == 1;
  endfunction

  // Stand-in for the upstream mask block: OR of peers' published one-hot digits.
  function automatic grid_t mask_of(grid_t r);
    grid_t m;
    m = '0;
    for (int i = 0; i < 81; i++)
      for (int j = 0; j < 81; j++)
        if (is_peer(i, j)) m[i*9 +: 9] = m[i*9 +: 9] | r[j*9 +: 9];
    return m;
  endfunction

  assign puzzle_mask_bin = mask_of(puzzle_reg_bin);

  // ---------------- behavioural model ----------------
  function automatic grid_t fix_load(grid_t p);
    grid_t c;
    c = p;
    for (int i = 0; i < 81; i++)
      if (p[i*9 +: 9] == 9'd0) c[i*9 +: 9] = 9'h1FF;
    return c;
  endfunction

  function automatic grid_t model_step(grid_t c);
    grid_t n;
    logic [8:0] seen;
    n = c;
    for (int i = 0; i < 81; i++) begin
      if (!one(c[i*9 +: 9])) begin
        seen = '0;
        for (int j = 0; j < 81; j++)
          if (is_peer(i, j) && one(c[j*9 +: 9])) seen = seen | c[j*9 +: 9];
        n[i*9 +: 9] = c[i*9 +: 9] & ~seen;
      end
    end
    return n;
  endfunction

  function automatic bit has_empty(grid_t c);
    for (int i = 0; i < 81; i++)
      if (c[i*9 +: 9] == 9'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit all_one(grid_t c);
    for (int i = 0; i < 81; i++)
      if (!one(c[i*9 +: 9])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic grid_t published(grid_t c);
    grid_t r;
    r = '0;
    for (int i = 0; i < 81; i++)
      if (one(c[i*9 +: 9])) r[i*9 +: 9] = c[i*9 +: 9];
    return r;
  endfunction

  // Number of updates a whole run applies before it finishes.
  function automatic int model_run(grid_t p);
    grid_t c, n;
    int it;
    c = fix_load(p);
    it = 0;
    while (1) begin
      if (has_empty(c) || all_one(c)) break;
      n = model_step(c);
      if (n == c || it == MAX_ITER) break;
      c = n;
      it++;
    end
    return it;
  endfunction

  // phase: 0 idle, 1 loading, 2 iterating, 3 finished
  int    m_phase = 0;
  grid_t m_cand  = '0;
  int    m_iter  = 0;
  bit    m_sol = 0, m_err = 0, m_stk = 0, m_to = 0;

  initial forever begin
    grid_t nxt;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_phase = 0; m_cand = '0; m_iter = 0;
      m_sol = 0; m_err = 0; m_stk = 0; m_to = 0;
    end else begin
      case (m_phase)
        0, 3: if (start) begin
          m_phase = 1; m_cand = fix_load(load_puzzle); m_iter = 0;
          m_sol = 0; m_err = 0; m_stk = 0; m_to = 0;
        end
        1: m_phase = 2;
        default: begin
          nxt = model_step(m_cand);
          if (has_empty(m_cand))      begin m_err = 1; m_phase = 3; end
          else if (all_one(m_cand))   begin m_sol = 1; m_phase = 3; end
          else if (nxt == m_cand)     begin m_stk = 1; m_phase = 3; end
          else if (m_iter == MAX_ITER) begin m_to = 1; m_phase = 3; end
          else begin m_cand = nxt; m_iter++; end
        end
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string nm, input grid_t act, input grid_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("busy", grid_t'(busy), grid_t'(m_phase == 1 || m_phase == 2));
      check("done", grid_t'(done), grid_t'(m_phase == 3));
      check("iter_count", grid_t'(iter_count), grid_t'(m_iter));
      check("cand_out", cand_out, m_cand);
      check("puzzle_reg_bin", puzzle_reg_bin, published(m_cand));
      if (m_phase == 3)
        check("flags", grid_t'({solved, error, stuck, timeout}),
              grid_t'({m_sol, m_err, m_stk, m_to}));
    end
  end

  // ---------------- drivers ----------------
  task automatic do_start(input grid_t p);
    @(negedge clk); #1;
    load_puzzle = p;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(posedge clk); n++; #1;
      if (done) break;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL wait_done act=no_done exp=done_within_%0d", budget);
    end
  endtask

  function automatic grid_t gen_grid();
    int perm[9];
    int t, j;
    grid_t g;
    for (int k = 0; k < 9; k++) perm[k] = k;
    for (int k = 8; k > 0; k--) begin
      j = $urandom_range(k, 0);
      t = perm[k]; perm[k] = perm[j]; perm[j] = t;
    end
    g = '0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        g[(r*9+c)*9 +: 9] = 9'd1 << perm[(r*3 + r/3 + c) % 9];
    return g;
  endfunction

  function automatic grid_t clear_cells(grid_t g, int pct);
    grid_t p;
    p = g;
    for (int i = 0; i < 81; i++)
      if ($urandom_range(99, 0) < pct) p[i*9 +: 9] = 9'd0;
    return p;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    grid_t g, p, longp;
    int n, k, long_k;
    bit found;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", grid_t'(busy), '0);
    check("rst_done", grid_t'(done), '0);
    check("rst_flags", grid_t'({solved, error, stuck, timeout}), '0);
    check("rst_cand", cand_out, '0);
    check("rst_iter", grid_t'(iter_count), '0);
    #1 rst = 1'b0;

    // Fully solved grid: finished on the first evaluation.
    g = gen_grid();
    do_start(g);
    wait_done(10, n);
    check("solved_latency", grid_t'(n), grid_t'(2));
    check("solved_flag", grid_t'(solved), grid_t'(1));
    check("solved_iter", grid_t'(iter_count), '0);
    check("solved_cand", cand_out, g);

    // One hole at (4,4) is filled by its peers in one update.
    p = g;
    p[40*9 +: 9] = 9'd0;
    do_start(p);
    wait_done(10, n);
    check("hole_solved", grid_t'(solved), grid_t'(1));
    check("hole_iter", grid_t'(iter_count), grid_t'(1));
    check("hole_cell", grid_t'(cand_out[40*9 +: 9]), grid_t'(g[40*9 +: 9]));

    // All-empty board: nothing decided, no progress.
    do_start('0);
    wait_done(10, n);
    check("empty_stuck", grid_t'(stuck), grid_t'(1));
    check("empty_iter", grid_t'(iter_count), '0);
    check("empty_cand", cand_out, '1);

    // Row 0 holds 1..8, (1,8) holds 9: cell (0,8) loses every candidate.
    p = '0;
    for (int c = 0; c < 8; c++) p[c*9 +: 9] = 9'd1 << c;
    p[17*9 +: 9] = 9'h100;
    do_start(p);
    wait_done(10, n);
    check("row_error", grid_t'(error), grid_t'(1));
    check("row_iter", grid_t'(iter_count), grid_t'(1));
    check("row_cell08", grid_t'(cand_out[8*9 +: 9]), '0);

    // Find a puzzle that needs several updates.
    found = 0; longp = '0; long_k = 0;
    for (int t = 0; t < 300 && !found; t++) begin
      p = clear_cells(gen_grid(), 60);
      k = model_run(p);
      if (k >= 4) begin found = 1; longp = p; long_k = k; end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL long_puzzle act=none exp=run_of_4_updates");
    end

    // start while busy is ignored.
    do_start(longp);
    @(negedge clk); #1;
    load_puzzle = '0;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(200, n);
    check("busy_start_iter", grid_t'(iter_count), grid_t'(long_k));

    // Restart from DONE clears the flags while loading.
    do_start(g);
    check("restart_busy", grid_t'(busy), grid_t'(1));
    check("restart_done", grid_t'(done), '0);
    check("restart_flags", grid_t'({solved, error, stuck, timeout}), '0);
    wait_done(10, n);

    // Reset in the middle of a run.
    do_start(longp);
    n = 0;
    while (n < 50 && iter_count != 7'd3) begin
      @(posedge clk); n++; #1;
    end
    check("reach_iter3", grid_t'(iter_count), grid_t'(3));
    rst = 1'b1;
    #1;
    check("midrst_busy", grid_t'(busy), '0);
    check("midrst_done", grid_t'(done), '0);
    check("midrst_cand", cand_out, '0);
    check("midrst_iter", grid_t'(iter_count), '0);
    @(negedge clk); #1;
    rst = 1'b0;
    do_start(g);
    wait_done(10, n);
    check("after_rst_solved", grid_t'(solved), grid_t'(1));

    // Random puzzles, some with corrupted cells.
    for (int t = 0; t < 25; t++) begin
      p = clear_cells(gen_grid(), $urandom_range(70, 20));
      if ($urandom_range(3, 0) == 0)
        p[$urandom_range(80, 0)*9 +: 9] = 9'($urandom_range(511, 1));
      do_start(p);
      wait_done(200, n);
      check("rand_iter", grid_t'(iter_count), grid_t'(model_run(p)));
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
